// File: rtl/frame_config_sequencer_pkg.sv
// Shared types and header layout for the frame configuration sequencer.
package frame_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    STROBE  = 3'd2,
    DONE    = 3'd3,
    DISCARD = 3'd4
  } cfg_state_t;

  localparam logic [7:0] SYNC_BYTE     = 8'hFA;
  localparam int         HDR_SYNC_LSB  = 24;
  localparam int         HDR_COL_LSB   = 16;
  localparam int         HDR_NUM_LSB   = 8;
  localparam int         HDR_FIRST_LSB = 0;

endpackage

// File: rtl/frame_config_sequencer_if.sv
// Valid/ready word stream from the bitstream front-end.
interface frame_config_sequencer_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, s_valid, input s_ready);
  modport slave  (input s_data, s_valid, output s_ready);
endinterface

// File: rtl/frame_config_sequencer_strobe_decoder.sv
// Column/frame index to one-hot frame strobe; bit index is col*MAX_FRAMES+frame.
module frame_strobe_decoder #(
  parameter int NUM_COLUMNS = 16,
  parameter int MAX_FRAMES  = 20,
  parameter int COL_W       = $clog2(NUM_COLUMNS),
  parameter int FR_W        = $clog2(MAX_FRAMES + 1)
) (
  input  logic [COL_W-1:0]                  column,
  input  logic [FR_W-1:0]                   frame,
  input  logic                              en,
  output logic [NUM_COLUMNS*MAX_FRAMES-1:0] strobe
);

  for (genvar c = 0; c < NUM_COLUMNS; c++) begin : g_col
    for (genvar f = 0; f < MAX_FRAMES; f++) begin : g_frm
      assign strobe[c*MAX_FRAMES+f] = en && (column == COL_W'(c)) && (frame == FR_W'(f));
    end
  end

endmodule

// File: rtl/frame_config_sequencer.sv
// Assembles ROWS-word configuration frames from a header-led packet stream and
// pulses one frame strobe per completed frame while FrameData is held stable.
module frame_config_sequencer
  import frame_cfg_pkg::*;
#(
  parameter int ROWS        = 16,
  parameter int NUM_COLUMNS = 16,
  parameter int MAX_FRAMES  = 20
) (
  input  logic                              CLK,
  input  logic                              resetn,
  frame_config_sequencer_if.slave           s,
  input  logic                              err_clr,
  output logic [ROWS*32-1:0]                FrameData,
  output logic [NUM_COLUMNS*MAX_FRAMES-1:0] FrameStrobe,
  output logic                              busy,
  output logic                              cfg_done,
  output logic                              error
);

  localparam int WC_W  = $clog2(ROWS);
  localparam int FR_W  = $clog2(MAX_FRAMES + 1);
  localparam int COL_W = $clog2(NUM_COLUMNS);
  localparam int DC_W  = $clog2(MAX_FRAMES * ROWS + 1);

  cfg_state_t             state;
  logic [ROWS-1:0][31:0]  frame_q;
  logic [WC_W-1:0]        wcnt;
  logic [FR_W-1:0]        fidx;
  logic [FR_W-1:0]        frem;
  logic [COL_W-1:0]       col;
  logic [DC_W-1:0]        dcnt;

  logic       acc, hdr_acc, hdr_bad, hdr_disc;
  logic [7:0] hdr_col, hdr_num, hdr_first;
  logic [8:0] hdr_end;

  assign acc       = s.s_valid && s.s_ready;
  assign hdr_col   = s.s_data[HDR_COL_LSB +: 8];
  assign hdr_num   = s.s_data[HDR_NUM_LSB +: 8];
  assign hdr_first = s.s_data[HDR_FIRST_LSB +: 8];
  assign hdr_end   = {1'b0, hdr_first} + {1'b0, hdr_num};
  assign hdr_acc   = (state == IDLE) && acc && (s.s_data[HDR_SYNC_LSB +: 8] == SYNC_BYTE);
  assign hdr_bad   = ({1'b0, hdr_col} >= 9'(NUM_COLUMNS)) || (hdr_num == 8'd0) ||
                     (hdr_end > 9'(MAX_FRAMES));
  // A bad header whose count is still plausible carries a payload we must swallow.
  assign hdr_disc  = (hdr_num != 8'd0) && ({1'b0, hdr_num} <= 9'(MAX_FRAMES));

  assign s.s_ready = (state == IDLE) || (state == LOAD) || (state == DISCARD);
  assign busy      = (state != IDLE);
  assign cfg_done  = (state == DONE);
  assign FrameData = frame_q;

  frame_strobe_decoder #(
    .NUM_COLUMNS(NUM_COLUMNS),
    .MAX_FRAMES (MAX_FRAMES)
  ) u_dec (
    .column(col),
    .frame (fidx),
    .en    (state == STROBE),
    .strobe(FrameStrobe)
  );

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      frame_q <= '0;
      wcnt    <= '0;
      fidx    <= '0;
      frem    <= '0;
      col     <= '0;
      dcnt    <= '0;
      error   <= 1'b0;
    end else begin
      if (hdr_acc && hdr_bad) error <= 1'b1;
      else if (err_clr)       error <= 1'b0;

      case (state)
        IDLE: if (hdr_acc) begin
          if (!hdr_bad) begin
            col   <= hdr_col[COL_W-1:0];
            fidx  <= FR_W'(hdr_first);
            frem  <= FR_W'(hdr_num);
            wcnt  <= '0;
            state <= LOAD;
          end else if (hdr_disc) begin
            dcnt  <= DC_W'(hdr_num) * DC_W'(ROWS);
            state <= DISCARD;
          end
        end
        LOAD: if (acc) begin
          frame_q[wcnt] <= s.s_data;
          wcnt          <= wcnt + 1'b1;
          if (wcnt == WC_W'(ROWS - 1)) state <= STROBE;
        end
        STROBE: begin
          wcnt <= '0;
          if (frem == FR_W'(1)) begin
            state <= DONE;
          end else begin
            fidx  <= fidx + 1'b1;
            frem  <= frem - 1'b1;
            state <= LOAD;
          end
        end
        DONE: state <= IDLE;
        DISCARD: if (acc) begin
          dcnt <= dcnt - 1'b1;
          if (dcnt == DC_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Randomized and directed bench for frame_config_sequencer against a packet-level model.
module tb_frame_config_sequencer;

  localparam int ROWS = 16;
  localparam int NC   = 16;
  localparam int MF   = 20;
  localparam int NS   = NC * MF;

  logic CLK = 1'b0;
  logic resetn = 1'b0;
  logic err_clr = 1'b0;
  logic [ROWS*32-1:0] FrameData;
  logic [NS-1:0]      FrameStrobe;
  logic busy, cfg_done, error;

  frame_config_sequencer_if dif();

  frame_config_sequencer #(.ROWS(ROWS), .NUM_COLUMNS(NC), .MAX_FRAMES(MF)) dut (
    .CLK(CLK), .resetn(resetn), .s(dif), .err_clr(err_clr),
    .FrameData(FrameData), .FrameStrobe(FrameStrobe),
    .busy(busy), .cfg_done(cfg_done), .error(error)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int gap_lo   = 0;
  int gap_hi   = 0;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: frame contents, packet progress, and a queue of the non-accepting
  // cycles (strobe index >= 0, or -1 for the done cycle) each packet owes.
  logic [31:0] m_fd [ROWS] = '{default: 32'h0};
  int   m_sched[$];
  int   m_frames_left = 0, m_word = 0, m_frame = 0, m_col = 0, m_disc = 0;
  bit   m_err = 1'b0;
  int   mc, mn, mf;
  bit   m_set;
  logic [31:0] mw;

  initial forever begin
    @(posedge CLK or negedge resetn);
    if (!resetn) begin
      for (int k = 0; k < ROWS; k++) m_fd[k] = 32'h0;
      m_sched.delete();
      m_frames_left = 0; m_word = 0; m_disc = 0; m_err = 1'b0;
    end else begin
      m_set = 1'b0;
      if (m_sched.size() > 0) begin
        void'(m_sched.pop_front());
      end else if (dif.s_valid) begin
        mw = dif.s_data;
        if (m_disc > 0) m_disc--;
        else if (m_frames_left > 0) begin
          m_fd[m_word] = mw;
          m_word++;
          if (m_word == ROWS) begin
            m_word = 0;
            m_sched.push_back(m_col * MF + m_frame);
            m_frame++;
            m_frames_left--;
            if (m_frames_left == 0) m_sched.push_back(-1);
          end
        end else if (mw[31:24] == 8'hFA) begin
          mc = int'(mw[23:16]); mn = int'(mw[15:8]); mf = int'(mw[7:0]);
          if (mc >= NC || mn == 0 || mf + mn > MF) begin
            m_set = 1'b1;
            if (mn >= 1 && mn <= MF) m_disc = mn * ROWS;
          end else begin
            m_col = mc; m_frame = mf; m_frames_left = mn; m_word = 0;
          end
        end
      end
      if (m_set) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  end

  // Every-cycle compare plus a log of observed strobes / done pulses.
  int seen_idx[$], seen_cyc[$], done_cyc[$];
  logic [NS-1:0]      e_strobe;
  logic [ROWS*32-1:0] e_fd;
  logic e_ready, e_busy, e_done;

  initial forever begin
    @(negedge CLK);
    cyc++;
    e_strobe = '0; e_ready = 1'b1; e_done = 1'b0;
    e_busy = (m_frames_left > 0) || (m_disc > 0);
    if (m_sched.size() > 0) begin
      e_ready = 1'b0; e_busy = 1'b1;
      if (m_sched[0] >= 0) e_strobe[m_sched[0]] = 1'b1;
      else e_done = 1'b1;
    end
    for (int k = 0; k < ROWS; k++) e_fd[k*32 +: 32] = m_fd[k];
    check("s_ready", dif.s_ready, e_ready);
    check("busy", busy, e_busy);
    check("cfg_done", cfg_done, e_done);
    check("error", error, m_err);
    check("FrameStrobe", FrameStrobe, e_strobe);
    check("FrameData", FrameData, e_fd);
    for (int b = 0; b < NS; b++)
      if (FrameStrobe[b]) begin seen_idx.push_back(b); seen_cyc.push_back(cyc); end
    if (cfg_done) done_cyc.push_back(cyc);
  end

  function automatic logic [31:0] hdr(input int c, input int n, input int f);
    return {8'hFA, 8'(c), 8'(n), 8'(f)};
  endfunction

  task automatic settle(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic clear_obs();
    seen_idx.delete(); seen_cyc.delete(); done_cyc.delete();
  endtask

  task automatic send_word(input logic [31:0] w);
    int t;
    repeat ($urandom_range(gap_hi, gap_lo)) begin
      @(negedge CLK); dif.s_valid = 1'b0; dif.s_data = $urandom;
    end
    @(negedge CLK);
    dif.s_valid = 1'b1; dif.s_data = w;
    t = 0;
    while (!dif.s_ready && t < 400) begin @(negedge CLK); t++; end
    if (!dif.s_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: word %h not accepted within 400 cycles", w);
    end else @(posedge CLK);
    #1;
    dif.s_valid = 1'b0; dif.s_data = $urandom;
  endtask

  task automatic send_packet(input int c, input int n, input int f, input bit rnd);
    send_word(hdr(c, n, f));
    if (n >= 1 && n <= MF)
      for (int fr = 0; fr < n; fr++)
        for (int k = 0; k < ROWS; k++)
          send_word(rnd ? 32'($urandom) : 32'h1000 + 32'(fr * 256 + k));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((m_sched.size() > 0 || m_frames_left > 0 || m_disc > 0) && t < 2000) begin
      @(negedge CLK); t++;
    end
    if (t >= 2000) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: model still busy after 2000 cycles");
    end
    settle(2);
  endtask

  logic [ROWS*32-1:0] lit_fd;
  int pc, pn, pf;

  initial begin
    dif.s_valid = 1'b0; dif.s_data = 32'h0;
    settle(3);
    check("reset s_ready", dif.s_ready, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset FrameData", FrameData, '0);
    check("reset FrameStrobe", FrameStrobe, '0);
    check("reset error", error, 1'b0);
    @(negedge CLK); resetn = 1'b1;
    settle(1);

    // Single frame to column 3, frame 2
    clear_obs();
    send_packet(3, 1, 2, 1'b0);
    wait_idle();
    for (int k = 0; k < ROWS; k++) lit_fd[k*32 +: 32] = 32'h1000 + 32'(k);
    check("t1 FrameData", FrameData, lit_fd);
    check("t1 strobe count", seen_idx.size(), 1);
    check("t1 strobe bit", (seen_idx.size() > 0) ? seen_idx[0] : -1, 62);
    check("t1 done count", done_cyc.size(), 1);
    check("t1 done follows strobe",
          (done_cyc.size() > 0 && seen_cyc.size() > 0) ? done_cyc[0] - seen_cyc[0] : -1, 1);

    // Three frames with s_valid toggling every other cycle
    clear_obs();
    gap_lo = 1; gap_hi = 1;
    send_packet(0, 3, 0, 1'b0);
    wait_idle();
    check("t2 strobe count", seen_idx.size(), 3);
    for (int i = 0; i < 3; i++)
      check("t2 strobe order", (seen_idx.size() > i) ? seen_idx[i] : -1, i);

    // Bad column with discard, then a good packet, then err_clr
    gap_lo = 0; gap_hi = 2;
    clear_obs();
    send_word(hdr(16, 1, 0));
    settle(1);
    check("t3 error set", error, 1'b1);
    check("t3 busy discard", busy, 1'b1);
    for (int k = 0; k < ROWS; k++) send_word($urandom);
    wait_idle();
    check("t3 no strobe on discard", seen_idx.size(), 0);
    send_packet(7, 2, 5, 1'b1);
    wait_idle();
    check("t3 strobe count", seen_idx.size(), 2);
    check("t3 strobe a", (seen_idx.size() > 0) ? seen_idx[0] : -1, 145);
    check("t3 strobe b", (seen_idx.size() > 1) ? seen_idx[1] : -1, 146);
    check("t3 error sticky", error, 1'b1);
    @(negedge CLK); err_clr = 1'b1;
    @(negedge CLK); err_clr = 1'b0;
    #1;
    check("t3 error cleared", error, 1'b0);

    // Non-sync words in IDLE
    clear_obs();
    send_word(32'h12345678);
    send_word(32'h00FA0000);
    settle(2);
    check("t4 busy", busy, 1'b0);
    check("t4 no strobe", seen_idx.size(), 0);
    check("t4 no error", error, 1'b0);

    // Reset in the middle of a frame
    clear_obs();
    send_word(hdr(5, 1, 0));
    for (int k = 0; k < 5; k++) send_word($urandom);
    @(negedge CLK); #2 resetn = 1'b0;
    #1;
    check("t5 FrameData", FrameData, '0);
    check("t5 busy", busy, 1'b0);
    check("t5 s_ready", dif.s_ready, 1'b1);
    check("t5 FrameStrobe", FrameStrobe, '0);
    check("t5 cfg_done", cfg_done, 1'b0);
    repeat (2) @(negedge CLK);
    resetn = 1'b1;
    check("t5 no strobe", seen_idx.size(), 0);
    settle(1);
    clear_obs();
    send_packet(9, 1, 19, 1'b1);
    wait_idle();
    check("t5 recovery strobe", (seen_idx.size() == 1) ? seen_idx[0] : -1, 199);

    // Bad header with err_clr in the same cycle: set wins
    clear_obs();
    err_clr = 1'b1;
    send_word(hdr(2, 2, 19));
    err_clr = 1'b0;
    settle(1);
    check("t6 error set wins", error, 1'b1);
    for (int k = 0; k < 2 * ROWS; k++) send_word($urandom);
    wait_idle();
    check("t6 no strobe", seen_idx.size(), 0);

    // Random packets, garbage words and err_clr
    for (int p = 0; p < 12; p++) begin
      gap_lo = 0; gap_hi = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) send_word({8'h12, 24'($urandom)});
      pc = $urandom_range(0, 16);
      pn = $urandom_range(0, 5);
      pf = $urandom_range(0, 20);
      if (p == 4) begin pc = 1; pn = 21; pf = 0; end
      if (p == 7) begin pc = 15; pn = 20; pf = 0; end
      err_clr = ($urandom_range(0, 3) == 0);
      send_packet(pc, pn, pf, 1'b1);
      err_clr = 1'b0;
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
